// File: rtl/colour_pkg.sv
// Shared colour-space constants and helpers for the HSV/RGB565 display pipelines.
// This package is also imported by the hue-detect pipeline, so treat every name here as a shared interface.
package colour_pkg;

   localparam int HUE_MAX    = 360;
   localparam int HUE_SECTOR = 60;
   localparam int FRAC_MULT  = 1092;

   localparam int R_MSB = 15;
   localparam int R_LSB = 11;
   localparam int R_W   = 5;
   localparam int G_MSB = 10;
   localparam int G_LSB = 5;
   localparam int G_W   = 6;
   localparam int B_MSB = 4;
   localparam int B_LSB = 0;
   localparam int B_W   = 5;

   typedef enum logic [2:0] {
      SECTOR_0 = 3'd0,
      SECTOR_1 = 3'd1,
      SECTOR_2 = 3'd2,
      SECTOR_3 = 3'd3,
      SECTOR_4 = 3'd4,
      SECTOR_5 = 3'd5
   } sector_t;

   // Each 8-bit channel keeps only its top bits. The low bits are dropped without rounding.
   function automatic logic [15:0] packRgb565(input logic [7:0] r, input logic [7:0] g,
                                              input logic [7:0] b);
      logic [15:0] w;
      w = 16'h0000;
      w[R_MSB:R_LSB] = r[7:8-R_W];
      w[G_MSB:G_LSB] = g[7:8-G_W];
      w[B_MSB:B_LSB] = b[7:8-B_W];
      return w;
   endfunction

endpackage

// File: rtl/hsv_scale.sv
// Combinational brightness scaler: y = (V * (256 - x)) >> 8.
// The result always fits in 8 bits because 255 * 256 >> 8 = 255.
module hsv_scale (
   input  logic [7:0] i_val,
   input  logic [7:0] i_x,
   output logic [7:0] o_y
);

   assign o_y = 8'(({8'd0, i_val} * (16'd256 - {8'd0, i_x})) >> 8);

endmodule

// File: rtl/hsv_to_rgb565.sv
// Three-stage HSV to RGB565 converter. The stages are sector split, scaled terms, and select/pack.
// It accepts one pixel per cycle and has no backpressure. Bubbles pass through unchanged.
module hsv_to_rgb565
   import colour_pkg::*;
#(
   parameter int LATENCY = 3
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] i_hue,
   input  logic [7:0]  i_sat,
   input  logic [7:0]  i_val,
   input  logic        i_valid,
   output logic [15:0] o_data,
   output logic        o_valid
);

   if (LATENCY != 3) begin : gIllegalLatency
      $error("hsv_to_rgb565: LATENCY must be 3");
   end

   logic [8:0]  w_hueC;
   sector_t     w_sector;
   logic [8:0]  w_base;
   logic [5:0]  w_rem;
   logic [7:0]  w_f;

   logic        r_s0Valid;
   sector_t     r_s0Sector;
   logic [7:0]  r_s0F;
   logic [7:0]  r_s0Sat;
   logic [7:0]  r_s0Val;

   logic [7:0]  w_sf;
   logic [7:0]  w_sfc;
   logic [7:0]  w_p;
   logic [7:0]  w_q;
   logic [7:0]  w_t;

   logic        r_s1Valid;
   sector_t     r_s1Sector;
   logic [7:0]  r_s1P;
   logic [7:0]  r_s1Q;
   logic [7:0]  r_s1T;
   logic [7:0]  r_s1Val;

   logic [7:0]  w_r;
   logic [7:0]  w_g;
   logic [7:0]  w_b;

   logic        r_valid;
   logic [15:0] r_data;

   // Any hue of 360 or more is treated as red.
   // The sector comes from threshold compares, so no divider is needed.
   always_comb begin
      w_hueC   = (i_hue > 16'(HUE_MAX - 1)) ? 9'd0 : i_hue[8:0];
      w_sector = SECTOR_0;
      w_base   = 9'd0;
      if (w_hueC >= 9'(5 * HUE_SECTOR)) begin
         w_sector = SECTOR_5;
         w_base   = 9'(5 * HUE_SECTOR);
      end else if (w_hueC >= 9'(4 * HUE_SECTOR)) begin
         w_sector = SECTOR_4;
         w_base   = 9'(4 * HUE_SECTOR);
      end else if (w_hueC >= 9'(3 * HUE_SECTOR)) begin
         w_sector = SECTOR_3;
         w_base   = 9'(3 * HUE_SECTOR);
      end else if (w_hueC >= 9'(2 * HUE_SECTOR)) begin
         w_sector = SECTOR_2;
         w_base   = 9'(2 * HUE_SECTOR);
      end else if (w_hueC >= 9'(HUE_SECTOR)) begin
         w_sector = SECTOR_1;
         w_base   = 9'(HUE_SECTOR);
      end
      w_rem = 6'(w_hueC - w_base);
      w_f   = 8'(({10'd0, w_rem} * 16'(FRAC_MULT)) >> 8);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s0Valid  <= 1'b0;
         r_s0Sector <= SECTOR_0;
         r_s0F      <= 8'd0;
         r_s0Sat    <= 8'd0;
         r_s0Val    <= 8'd0;
      end else begin
         r_s0Valid <= i_valid;
         if (i_valid) begin
            r_s0Sector <= w_sector;
            r_s0F      <= w_f;
            r_s0Sat    <= i_sat;
            r_s0Val    <= i_val;
         end
      end
   end

   assign w_sf  = 8'(({8'd0, r_s0Sat} * {8'd0, r_s0F}) >> 8);
   assign w_sfc = 8'(({8'd0, r_s0Sat} * {8'd0, 8'd255 - r_s0F}) >> 8);

   hsv_scale uScaleP (.i_val(r_s0Val), .i_x(r_s0Sat), .o_y(w_p));
   hsv_scale uScaleQ (.i_val(r_s0Val), .i_x(w_sf),    .o_y(w_q));
   hsv_scale uScaleT (.i_val(r_s0Val), .i_x(w_sfc),   .o_y(w_t));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1Valid  <= 1'b0;
         r_s1Sector <= SECTOR_0;
         r_s1P      <= 8'd0;
         r_s1Q      <= 8'd0;
         r_s1T      <= 8'd0;
         r_s1Val    <= 8'd0;
      end else begin
         r_s1Valid <= r_s0Valid;
         if (r_s0Valid) begin
            r_s1Sector <= r_s0Sector;
            r_s1P      <= w_p;
            r_s1Q      <= w_q;
            r_s1T      <= w_t;
            r_s1Val    <= r_s0Val;
         end
      end
   end

   always_comb begin
      w_r = r_s1Val;
      w_g = r_s1T;
      w_b = r_s1P;
      case (r_s1Sector)
         SECTOR_0: begin w_r = r_s1Val; w_g = r_s1T;   w_b = r_s1P;   end
         SECTOR_1: begin w_r = r_s1Q;   w_g = r_s1Val; w_b = r_s1P;   end
         SECTOR_2: begin w_r = r_s1P;   w_g = r_s1Val; w_b = r_s1T;   end
         SECTOR_3: begin w_r = r_s1P;   w_g = r_s1Q;   w_b = r_s1Val; end
         SECTOR_4: begin w_r = r_s1T;   w_g = r_s1P;   w_b = r_s1Val; end
         SECTOR_5: begin w_r = r_s1Val; w_g = r_s1P;   w_b = r_s1Q;   end
         default:  begin w_r = r_s1Val; w_g = r_s1T;   w_b = r_s1P;   end
      endcase
   end

   // The output word keeps its previous value during bubbles, so downstream sees the last pixel.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid <= 1'b0;
         r_data  <= 16'h0000;
      end else begin
         r_valid <= r_s1Valid;
         if (r_s1Valid) begin
            r_data <= packRgb565(w_r, w_g, w_b);
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule
